// File: rtl/stream_pixel_unpacker.sv
// stream_pixel_unpacker
//   Splits words from a show-ahead input FIFO into a stream of single bytes.
//   One word is held at a time. Its strobed lanes are emitted in ascending
//   lane order, and lanes whose strobe is clear are skipped. The next word is
//   popped on the same edge that consumes the final byte of the held word, so
//   a non-empty FIFO and a ready consumer give one byte per cycle with no gaps.
//
// Ports
//   ACLK, ARESET       clock; asynchronous active-high reset
//   isif_*_dout        head-of-FIFO word: data, strobes, last and user flags
//   isif_empty_n       the FIFO holds at least one word
//   isif_read          pops the head word on this edge
//   pix_data/valid/ready/last/user   byte output handshake
//   byte_cnt           bytes accepted so far in the current packet
//   err_null_last      pulses when a dropped all-null word carried last=1
module stream_pixel_unpacker #(
  parameter int TBITS = 32,
  parameter int TBYTE = 4
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [TBITS-1:0] isif_data_dout,
  input  logic [TBYTE-1:0] isif_strb_dout,
  input  logic             isif_last_dout,
  input  logic             isif_user_dout,
  input  logic             isif_empty_n,
  output logic             isif_read,
  output logic [7:0]       pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             pix_user,
  output logic [15:0]      byte_cnt,
  output logic             err_null_last
);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [TBITS-1:0] data_q, data_d;
  logic [TBYTE-1:0] mask_q, mask_d;
  logic             last_q, last_d;
  logic             user_q, user_d;
  logic             first_q, first_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d;
  logic             err_q, err_d;

  logic [TBYTE-1:0] low_bit;
  logic             one_left;
  logic             handshake;

  // Isolate the lowest remaining lane. When exactly one lane is left, the
  // isolated bit equals the whole mask.
  always_comb begin
    low_bit  = mask_q & (~mask_q + TBYTE'(1));
    one_left = (mask_q != '0) && (mask_q == low_bit);
  end

  // Output decode. pix_data reads as zero whenever nothing is held.
  always_comb begin
    pix_data = 8'h00;
    for (int i = 0; i < TBYTE; i++) begin
      if (low_bit[i]) begin
        pix_data = data_q[8*i +: 8];
      end
    end
    pix_valid     = (state_q == S_HOLD);
    pix_last      = pix_valid && last_q && one_left;
    pix_user      = pix_valid && user_q && first_q;
    handshake     = pix_valid && pix_ready;
    isif_read     = !ARESET && isif_empty_n &&
                    ((state_q == S_EMPTY) || (handshake && one_left));
    byte_cnt      = byte_cnt_q;
    err_null_last = err_q;
  end

  // Next-state logic. The handshake retires the current lane first. A pop
  // then overwrites the whole holding register. A pop only occurs when the
  // register is empty or is being emptied on this edge.
  always_comb begin
    data_d     = data_q;
    mask_d     = mask_q;
    last_d     = last_q;
    user_d     = user_q;
    first_d    = first_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = 1'b0;

    if (handshake) begin
      mask_d  = mask_q & ~low_bit;
      first_d = 1'b0;
      // The end of a packet clears the count before a frame start sets it.
      // A single byte that is both first and last therefore leaves zero.
      if (pix_last) begin
        byte_cnt_d = 16'd0;
      end else if (pix_user) begin
        byte_cnt_d = 16'd1;
      end else if (byte_cnt_q != 16'hFFFF) begin
        byte_cnt_d = byte_cnt_q + 16'd1;
      end
    end

    if (isif_read) begin
      data_d  = isif_data_dout;
      mask_d  = isif_strb_dout;
      last_d  = isif_last_dout;
      user_d  = isif_user_dout;
      first_d = 1'b1;
      err_d   = (isif_strb_dout == '0) && isif_last_dout;
    end

    state_d = (mask_d != '0) ? S_HOLD : S_EMPTY;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_EMPTY;
      data_q     <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      user_q     <= 1'b0;
      first_q    <= 1'b0;
      byte_cnt_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      user_q     <= user_d;
      first_q    <= first_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_stream_pixel_unpacker.sv
// tb_stream_pixel_unpacker
//   Drives the unpacker from a queue that behaves like a show-ahead FIFO.
//   Every cycle, the outputs are compared with a byte-queue reference model.
//   When a word is popped, the model expands it into the list of bytes that
//   must appear, in order, together with their last and user markers.
module tb_stream_pixel_unpacker;
  localparam int TBITS = 32;
  localparam int TBYTE = 4;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [TBITS-1:0] isif_data_dout;
  logic [TBYTE-1:0] isif_strb_dout;
  logic             isif_last_dout;
  logic             isif_user_dout;
  logic             isif_empty_n;
  logic             isif_read;
  logic [7:0]       pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_last;
  logic             pix_user;
  logic [15:0]      byte_cnt;
  logic             err_null_last;

  stream_pixel_unpacker #(.TBITS(TBITS), .TBYTE(TBYTE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .isif_data_dout(isif_data_dout), .isif_strb_dout(isif_strb_dout),
    .isif_last_dout(isif_last_dout), .isif_user_dout(isif_user_dout),
    .isif_empty_n(isif_empty_n), .isif_read(isif_read),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .pix_user(pix_user),
    .byte_cnt(byte_cnt), .err_null_last(err_null_last)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [TBITS-1:0] data;
    logic [TBYTE-1:0] strb;
    logic             last;
    logic             user;
  } word_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
  } pix_t;

  word_t       fifo[$];
  pix_t        held[$];
  logic [15:0] m_cnt;
  logic        m_err;
  logic        e_valid;
  logic        e_read;
  int          tests = 0;
  int          fails = 0;

  // Single comparison point: counts the test, and reports and counts a failure.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("[TB] %s observed value differs from expected", tag);
    end
  endtask

  // Present the head of the bench FIFO in show-ahead fashion.
  task automatic driveHead();
    if (fifo.size() != 0) begin
      isif_data_dout = fifo[0].data;
      isif_strb_dout = fifo[0].strb;
      isif_last_dout = fifo[0].last;
      isif_user_dout = fifo[0].user;
      isif_empty_n   = 1'b1;
    end else begin
      isif_data_dout = '0;
      isif_strb_dout = '0;
      isif_last_dout = 1'b0;
      isif_user_dout = 1'b0;
      isif_empty_n   = 1'b0;
    end
  endtask

  // Expand a popped word into the bytes that the consumer must see.
  task automatic loadWord(input word_t w);
    int n;
    int k;
    pix_t p;
    n = $countones(w.strb);
    k = 0;
    for (int i = 0; i < TBYTE; i++) begin
      if (w.strb[i]) begin
        p.data = w.data[8*i +: 8];
        p.user = w.user && (k == 0);
        p.last = w.last && (k == n - 1);
        held.push_back(p);
        k++;
      end
    end
    m_err = (n == 0) && w.last;
  endtask

  task automatic applyStimulus(input logic rdy);
    pix_ready = rdy;
    driveHead();
  endtask

  // One clock cycle: check at the falling edge, then advance the model
  // just after the rising edge.
  task automatic checkOutput(input string tag);
    pix_t p;
    word_t w;
    @(negedge ACLK);
    e_valid = (held.size() != 0);
    e_read  = (fifo.size() != 0) &&
              (!e_valid || (pix_ready && held.size() == 1));
    chk({tag, ".valid"}, {31'd0, pix_valid}, {31'd0, e_valid});
    chk({tag, ".read"}, {31'd0, isif_read}, {31'd0, e_read});
    chk({tag, ".err"}, {31'd0, err_null_last}, {31'd0, m_err});
    chk({tag, ".cnt"}, {16'd0, byte_cnt}, {16'd0, m_cnt});
    if (e_valid) begin
      chk({tag, ".data"}, {24'd0, pix_data}, {24'd0, held[0].data});
      chk({tag, ".last"}, {31'd0, pix_last}, {31'd0, held[0].last});
      chk({tag, ".user"}, {31'd0, pix_user}, {31'd0, held[0].user});
    end
    @(posedge ACLK);
    #1;
    if (e_valid && pix_ready) begin
      p = held.pop_front();
      if (p.last) m_cnt = 16'd0;
      else if (p.user) m_cnt = 16'd1;
      else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    m_err = 1'b0;
    if (e_read) begin
      w = fifo.pop_front();
      loadWord(w);
    end
  endtask

  task automatic runCycles(input string tag, input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(rdy);
      checkOutput(tag);
    end
  endtask

  task automatic pushWord(input logic [31:0] d, input logic [3:0] s, input logic l, input logic u);
    word_t w;
    w.data = d;
    w.strb = s;
    w.last = l;
    w.user = u;
    fifo.push_back(w);
  endtask

  // Assert reset at once and check that outputs clear immediately. Then hold
  // reset for two edges with the FIFO presented; nothing may be popped.
  task automatic doReset(input string tag);
    ARESET = 1'b1;
    driveHead();
    #1;
    chk({tag, ".rst_valid"}, {31'd0, pix_valid}, 32'd0);
    chk({tag, ".rst_last"}, {31'd0, pix_last}, 32'd0);
    chk({tag, ".rst_user"}, {31'd0, pix_user}, 32'd0);
    chk({tag, ".rst_read"}, {31'd0, isif_read}, 32'd0);
    chk({tag, ".rst_cnt"}, {16'd0, byte_cnt}, 32'd0);
    chk({tag, ".rst_err"}, {31'd0, err_null_last}, 32'd0);
    chk({tag, ".rst_data"}, {24'd0, pix_data}, 32'd0);
    held.delete();
    m_cnt = 16'd0;
    m_err = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      chk({tag, ".rst_hold_read"}, {31'd0, isif_read}, 32'd0);
      chk({tag, ".rst_hold_valid"}, {31'd0, pix_valid}, 32'd0);
    end
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask

  initial begin
    pix_ready = 1'b0;
    driveHead();
    doReset("init");
    runCycles("idle", 1'b1, 2);

    // One full word ending a packet.
    pushWord(32'h44332211, 4'hF, 1'b1, 1'b0);
    runCycles("single", 1'b1, 7);

    // Two words back to back must produce eight bytes without a gap.
    pushWord(32'h44332211, 4'hF, 1'b0, 1'b0);
    pushWord(32'h88776655, 4'hF, 1'b1, 1'b0);
    runCycles("b2b", 1'b1, 11);

    // Sparse strobes with frame start and packet end.
    pushWord(32'hDDCCBBAA, 4'b1010, 1'b1, 1'b1);
    runCycles("sparse", 1'b1, 4);

    // An all-null word carrying last is dropped and flagged.
    pushWord(32'hDEADBEEF, 4'h0, 1'b1, 1'b0);
    runCycles("null", 1'b1, 4);

    // Stall on the second byte for five cycles.
    pushWord(32'h44332211, 4'hF, 1'b1, 1'b1);
    runCycles("stall_a", 1'b1, 2);
    runCycles("stall_b", 1'b0, 5);
    runCycles("stall_c", 1'b1, 5);

    // Reset in mid-word; the next word must start again from byte 0.
    pushWord(32'h44332211, 4'hF, 1'b0, 1'b0);
    pushWord(32'h88776655, 4'hF, 1'b1, 1'b0);
    runCycles("midrst_a", 1'b1, 3);
    doReset("midrst");
    runCycles("midrst_b", 1'b1, 7);

    // Long packet that drives byte_cnt into saturation, then ends it.
    for (int i = 0; i < 16390; i++) begin
      pushWord($urandom, 4'hF, 1'b0, 1'b0);
    end
    pushWord(32'h0A0B0C0D, 4'hF, 1'b1, 1'b0);
    runCycles("sat", 1'b1, 65572);

    // Randomized traffic with random strobes, flags and back-pressure.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        pushWord($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end
      applyStimulus($urandom_range(0, 3) != 0);
      checkOutput("rand");
    end
    runCycles("drain", 1'b1, 4 * fifo.size() + 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
